pat_scan_ctrl: RTL and testbench

- Frame-level controller for the team's bit-serial pattern detector.
- Accepts a frame of 8-bit words over a valid/ready handshake and serializes each word MSB-first into an internal detector.
- Counts pattern hits and records the bit position of the first hit.
- Sits between a byte-wide source (host or FIFO) and status logic that consumes match results.

---
 rtl/pat_scan_ctrl_pkg.sv | 22 ++
 rtl/pat_scan_ctrl_if.sv | 21 ++
 rtl/pat_scan_ctrl_bit_det.sv | 60 ++++++
 rtl/pat_scan_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_pat_scan_ctrl.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pat_scan_ctrl_pkg.sv
// pat_scan_ctrl_pkg: shared definitions for the pattern scan controller
// (the pat_defs set): FSM state encoding, default pattern and the width
// helper for frame-relative bit indices.
// Optional build macro used by this block: PAT_PROG_EN (programmable pattern).
package pat_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_FIN   = 2'd3
  } scan_state_e;

  // First bit received is compared against bit 7.
  localparam logic [7:0] PAT_DEFAULT = 8'b0011_0111;

  // A frame holds up to 2^len_w-1 words of 8 bits, so bit indices need 3 extra bits.
  function automatic int bit_idx_w(input int len_w);
    return len_w + 3;
  endfunction

endpackage

// File: rtl/pat_scan_ctrl_if.sv
// pat_scan_ctrl_if: byte-wide valid/ready word stream into the scan controller.
// The source drives in_valid/in_data; the controller answers with in_ready.
interface pat_scan_ctrl_if;

  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );

endinterface

// File: rtl/pat_scan_ctrl_bit_det.sv
// pat_bit_det: bit-serial detector for one fixed-length 8-bit pattern.
// Keeps an 8-bit history plus a fill count so a match is only reported once
// eight real bits have arrived. Matches are non-overlapping: a hit clears
// the history. hit is registered; hit_next is the same decision one cycle
// earlier so the controller can update its counters in step with hit.
module pat_bit_det (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       bit_vld,
  input  logic       bit_in,
  input  logic [7:0] pattern,
  output logic       hit,
  output logic       hit_next
);

  logic [7:0] hist_q, hist_d;
  logic [3:0] fill_q, fill_d;
  logic       hit_q;
  logic [7:0] shifted;
  logic [3:0] fill_inc;

  // Shift the incoming bit into the history and decide whether it completes a match.
  always_comb begin
    shifted  = {hist_q[6:0], bit_in};
    fill_inc = (fill_q == 4'd8) ? 4'd8 : fill_q + 4'd1;
    hist_d   = hist_q;
    fill_d   = fill_q;
    hit_next = 1'b0;
    if (clr) begin
      hist_d = '0;
      fill_d = '0;
    end else if (bit_vld) begin
      if ((fill_inc == 4'd8) && (shifted == pattern)) begin
        hit_next = 1'b1;
        hist_d   = '0;
        fill_d   = '0;
      end else begin
        hist_d = shifted;
        fill_d = fill_inc;
      end
    end
  end

  // History, fill count and registered hit, cleared by the active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hist_q <= '0;
      fill_q <= '0;
      hit_q  <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      hit_q  <= hit_next;
    end
  end

  assign hit = hit_q;

endmodule

// File: rtl/pat_scan_ctrl.sv
// pat_scan_ctrl: frame-level controller for the bit-serial pattern detector.
// Accepts frame_len words over a valid/ready handshake, shifts each word
// MSB-first into pat_bit_det, counts hits (saturating) and records the
// frame-relative index of the last bit of the first hit.
// Build macro PAT_PROG_EN: adds pat_in, latched on an accepted start and
// used instead of the PAT parameter.
module pat_scan_ctrl
  import pat_scan_ctrl_pkg::*;
#(
  parameter int         LEN_W = 5,
  parameter int         CNT_W = 8,
  parameter logic [7:0] PAT   = PAT_DEFAULT
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [LEN_W-1:0]            frame_len,
`ifdef PAT_PROG_EN
  input  logic [7:0]                  pat_in,
`endif
  pat_scan_ctrl_if.slave              in_if,
  output logic                        busy,
  output logic                        done,
  output logic                        flag,
  output logic [CNT_W-1:0]            match_cnt,
  output logic                        found,
  output logic [bit_idx_w(LEN_W)-1:0] first_pos
);

  localparam int IDX_W = bit_idx_w(LEN_W);

  scan_state_e      state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] word_cnt_q, word_cnt_d;
  logic [LEN_W-1:0] word_cnt_inc;
  logic [7:0]       word_q, word_d;
  logic [2:0]       bit_sel_q, bit_sel_d;
  logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
  logic             found_q, found_d;
  logic [IDX_W-1:0] first_pos_q, first_pos_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             accept;
  logic             det_clr;
  logic             det_vld;
  logic             det_bit;
  logic             det_hit;
  logic             det_hit_next;
  logic [7:0]       pattern;

`ifdef PAT_PROG_EN
  logic [7:0]       pat_q, pat_d;
  assign pattern = pat_q;
`else
  assign pattern = PAT;
`endif

  // Detector controls: clear on an accepted start, feed one bit per SHIFT cycle.
  assign accept  = in_ready_q && in_if.in_valid;
  assign det_clr = (state_q == ST_IDLE) && start;
  assign det_vld = (state_q == ST_SHIFT);
  assign det_bit = word_q[bit_sel_q];

  pat_bit_det u_bit_det (
    .clk      (clk),
    .reset    (reset),
    .clr      (det_clr),
    .bit_vld  (det_vld),
    .bit_in   (det_bit),
    .pattern  (pattern),
    .hit      (det_hit),
    .hit_next (det_hit_next)
  );

  // Next-state, counter and result logic; outputs are registered from the next state.
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    word_cnt_d   = word_cnt_q;
    word_d       = word_q;
    bit_sel_d    = bit_sel_q;
    bit_idx_d    = bit_idx_q;
    match_cnt_d  = match_cnt_q;
    found_d      = found_q;
    first_pos_d  = first_pos_q;
`ifdef PAT_PROG_EN
    pat_d        = pat_q;
`endif
    word_cnt_inc = word_cnt_q + LEN_W'(1);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d       = frame_len;
          word_cnt_d  = '0;
          bit_idx_d   = '0;
          match_cnt_d = '0;
          found_d     = 1'b0;
          first_pos_d = '0;
`ifdef PAT_PROG_EN
          pat_d       = pat_in;
`endif
          state_d     = (frame_len == '0) ? ST_FIN : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          word_d    = in_if.in_data;
          bit_sel_d = 3'd7;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        bit_idx_d = bit_idx_q + IDX_W'(1);
        bit_sel_d = bit_sel_q - 3'd1;
        if (bit_sel_q == 3'd0) begin
          word_cnt_d = word_cnt_inc;
          state_d    = (word_cnt_inc == len_q) ? ST_FIN : ST_LOAD;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Results move in the same edge that raises flag, so they line up with it.
    if (det_hit_next) begin
      if (match_cnt_q != {CNT_W{1'b1}}) begin
        match_cnt_d = match_cnt_q + CNT_W'(1);
      end
      if (!found_q) begin
        found_d     = 1'b1;
        first_pos_d = bit_idx_q;
      end
    end

    in_ready_d = (state_d == ST_LOAD);
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_FIN);
  end

  // Single state register for FSM, counters and outputs; reset discards any partial word.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      word_cnt_q  <= '0;
      word_q      <= '0;
      bit_sel_q   <= '0;
      bit_idx_q   <= '0;
      match_cnt_q <= '0;
      found_q     <= 1'b0;
      first_pos_q <= '0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef PAT_PROG_EN
      pat_q       <= PAT;
`endif
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      word_cnt_q  <= word_cnt_d;
      word_q      <= word_d;
      bit_sel_q   <= bit_sel_d;
      bit_idx_q   <= bit_idx_d;
      match_cnt_q <= match_cnt_d;
      found_q     <= found_d;
      first_pos_q <= first_pos_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef PAT_PROG_EN
      pat_q       <= pat_d;
`endif
    end
  end

  assign in_if.in_ready = in_ready_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign flag           = det_hit;
  assign match_cnt      = match_cnt_q;
  assign found          = found_q;
  assign first_pos      = first_pos_q;

endmodule

// File: tb/tb_pat_scan_ctrl.sv
// tb_pat_scan_ctrl: directed, table-driven bench for pat_scan_ctrl.
// Two instances see identical stimulus: dut_a with default widths and
// dut_b with CNT_W=2 so saturation of match_cnt is visible.
// With PAT_PROG_EN defined, pat_in is tied to the default pattern.
module tb_pat_scan_ctrl;

  localparam int LEN_W     = 5;
  localparam int IDX_W     = LEN_W + 3;
  localparam int MAX_WORDS = 5;
  localparam int NUM_VEC   = 9;
  localparam int FRAME_LIM = 400;

  typedef struct packed {
    logic [LEN_W-1:0]              len;
    logic [0:MAX_WORDS-1][7:0]     words;
    logic [7:0]                    exp_cnt_a;
    logic [7:0]                    exp_cnt_b;
    logic                          exp_found;
    logic [IDX_W-1:0]              exp_first_pos;
    logic [7:0]                    exp_flags;
    logic [7:0]                    exp_first_flag;
    logic [7:0]                    exp_done_at;
  } vec_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [LEN_W-1:0] frame_len;
  logic             in_valid;
  logic [7:0]       in_data;
`ifdef PAT_PROG_EN
  logic [7:0]       pat_in;
`endif

  logic             busy_a, done_a, flag_a, found_a;
  logic [7:0]       cnt_a;
  logic [IDX_W-1:0] fp_a;
  logic             busy_b, done_b, flag_b, found_b;
  logic [1:0]       cnt_b;
  logic [IDX_W-1:0] fp_b;

  int n_compared;
  int n_mismatched;

  int m_flags_a, m_flags_b, m_dones, m_done_at, m_first_flag, m_ready_cnt, m_completed;

  vec_t vecs [NUM_VEC];

  pat_scan_ctrl_if if_a ();
  pat_scan_ctrl_if if_b ();

  assign if_a.in_valid = in_valid;
  assign if_a.in_data  = in_data;
  assign if_b.in_valid = in_valid;
  assign if_b.in_data  = in_data;

  pat_scan_ctrl #(.LEN_W(LEN_W), .CNT_W(8)) dut_a (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .frame_len (frame_len),
`ifdef PAT_PROG_EN
    .pat_in    (pat_in),
`endif
    .in_if     (if_a),
    .busy      (busy_a),
    .done      (done_a),
    .flag      (flag_a),
    .match_cnt (cnt_a),
    .found     (found_a),
    .first_pos (fp_a)
  );

  pat_scan_ctrl #(.LEN_W(LEN_W), .CNT_W(2)) dut_b (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .frame_len (frame_len),
`ifdef PAT_PROG_EN
    .pat_in    (pat_in),
`endif
    .in_if     (if_b),
    .busy      (busy_b),
    .done      (done_b),
    .flag      (flag_b),
    .match_cnt (cnt_b),
    .found     (found_b),
    .first_pos (fp_b)
  );

  // 10-unit clock period.
  always #5 clk = ~clk;

  // Hard stop in case something wedges outside the bounded waits.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Compare one value and tally the result.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Run one frame with in_valid held high, recording handshake and result timing.
  task automatic applyStimulus(input logic [LEN_W-1:0] len, input logic [0:MAX_WORDS-1][7:0] words);
    int cyc;
    int widx;
    m_flags_a = 0; m_flags_b = 0; m_dones = 0; m_done_at = 0;
    m_first_flag = 0; m_ready_cnt = 0; m_completed = 0;
    @(negedge clk);
    start     = 1'b1;
    frame_len = len;
    in_valid  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    widx  = 0;
    while (1) begin
      if (if_a.in_ready) begin
        m_ready_cnt++;
        if (widx < MAX_WORDS) in_data = words[widx];
        widx++;
      end
      if (flag_a) begin
        m_flags_a++;
        if (m_first_flag == 0) m_first_flag = cyc;
      end
      if (flag_b) m_flags_b++;
      if (done_a) begin
        m_dones++;
        m_done_at = cyc;
      end
      if ((m_dones > 0) && !busy_a) begin
        m_completed = 1;
        break;
      end
      if (cyc >= FRAME_LIM) break;
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
  endtask

  function automatic vec_t mk(input int len, input logic [0:MAX_WORDS-1][7:0] w,
                              input int ca, input int cb, input int fnd, input int fp,
                              input int nf, input int ff, input int da);
    vec_t v;
    v.len            = LEN_W'(len);
    v.words          = w;
    v.exp_cnt_a      = 8'(ca);
    v.exp_cnt_b      = 8'(cb);
    v.exp_found      = 1'(fnd);
    v.exp_first_pos  = IDX_W'(fp);
    v.exp_flags      = 8'(nf);
    v.exp_first_flag = 8'(ff);
    v.exp_done_at    = 8'(da);
    return v;
  endfunction

  initial begin
    int cyc;
    n_compared   = 0;
    n_mismatched = 0;
    reset     = 1'b0;
    start     = 1'b0;
    frame_len = '0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
`ifdef PAT_PROG_EN
    pat_in    = 8'h37;
`endif

    // len, words (word 0 leftmost), cnt_a, cnt_b, found, first_pos, flags, first flag cycle, done cycle
    vecs[0] = mk(1, {8'h37, 8'h00, 8'h00, 8'h00, 8'h00}, 1, 1, 1,  7, 1, 10, 10);
    vecs[1] = mk(2, {8'h03, 8'h70, 8'h00, 8'h00, 8'h00}, 1, 1, 1, 11, 1, 15, 19);
    vecs[2] = mk(3, {8'h37, 8'h37, 8'hFF, 8'h00, 8'h00}, 2, 2, 1,  7, 2, 10, 28);
    vecs[3] = mk(0, {8'h37, 8'h37, 8'h37, 8'h37, 8'h37}, 0, 0, 0,  0, 0,  0,  1);
    vecs[4] = mk(5, {8'h37, 8'h37, 8'h37, 8'h37, 8'h37}, 5, 3, 1,  7, 5, 10, 46);
    vecs[5] = mk(1, {8'h03, 8'h00, 8'h00, 8'h00, 8'h00}, 0, 0, 0,  0, 0,  0, 10);
    vecs[6] = mk(1, {8'h70, 8'h00, 8'h00, 8'h00, 8'h00}, 0, 0, 0,  0, 0,  0, 10);
    vecs[7] = mk(2, {8'h00, 8'h37, 8'h00, 8'h00, 8'h00}, 1, 1, 1, 15, 1, 19, 19);
    vecs[8] = mk(3, {8'hFF, 8'h03, 8'h7F, 8'h00, 8'h00}, 1, 1, 1, 19, 1, 24, 28);

    repeat (3) @(negedge clk);
    checkOutput("rst_busy",      busy_a,        0);
    checkOutput("rst_in_ready",  if_a.in_ready, 0);
    checkOutput("rst_done",      done_a,        0);
    checkOutput("rst_flag",      flag_a,        0);
    checkOutput("rst_match_cnt", cnt_a,         0);
    checkOutput("rst_found",     found_a,       0);
    checkOutput("rst_first_pos", fp_a,          0);
    checkOutput("rst_busy_b",    busy_b,        0);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("idle_busy", busy_a, 0);

    for (int i = 0; i < NUM_VEC; i++) begin
      applyStimulus(vecs[i].len, vecs[i].words);
      checkOutput($sformatf("v%0d_completed",  i), m_completed,  1);
      checkOutput($sformatf("v%0d_match_cnt",  i), cnt_a,        vecs[i].exp_cnt_a);
      checkOutput($sformatf("v%0d_match_cnt_b", i), cnt_b,       vecs[i].exp_cnt_b);
      checkOutput($sformatf("v%0d_found",      i), found_a,      vecs[i].exp_found);
      checkOutput($sformatf("v%0d_found_b",    i), found_b,      vecs[i].exp_found);
      checkOutput($sformatf("v%0d_first_pos",  i), fp_a,         vecs[i].exp_first_pos);
      checkOutput($sformatf("v%0d_first_pos_b", i), fp_b,        vecs[i].exp_first_pos);
      checkOutput($sformatf("v%0d_flags",      i), m_flags_a,    vecs[i].exp_flags);
      checkOutput($sformatf("v%0d_flags_b",    i), m_flags_b,    vecs[i].exp_flags);
      checkOutput($sformatf("v%0d_first_flag", i), m_first_flag, vecs[i].exp_first_flag);
      checkOutput($sformatf("v%0d_done_pulses", i), m_dones,     1);
      checkOutput($sformatf("v%0d_done_at",    i), m_done_at,    vecs[i].exp_done_at);
      checkOutput($sformatf("v%0d_ready_cycles", i), m_ready_cnt, 32'(vecs[i].len));
    end

    // Stall in LOAD with in_valid low; a start pulse with a new length must be ignored.
    @(negedge clk);
    start     = 1'b1;
    frame_len = 5'd1;
    in_valid  = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("stall%0d_in_ready", i), if_a.in_ready, 1);
      checkOutput($sformatf("stall%0d_busy", i),     busy_a,        1);
      if (i == 2) begin
        start     = 1'b1;
        frame_len = 5'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = 8'h37;
    cyc = 0;
    while (!done_a && (cyc < 40)) begin
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    checkOutput("stall_done_seen",  done_a, 1);
    checkOutput("stall_done_delay", cyc,    9);
    checkOutput("stall_flag_in_fin", flag_a, 1);
    checkOutput("stall_match_cnt",  cnt_a,  1);
    checkOutput("stall_first_pos",  fp_a,   7);
    @(negedge clk);
    checkOutput("stall_busy_after", busy_a,        0);
    checkOutput("stall_ready_after", if_a.in_ready, 0);

    // Reset while shifting the second word, after the first word already matched.
    @(negedge clk);
    start     = 1'b1;
    frame_len = 5'd2;
    in_valid  = 1'b1;
    in_data   = 8'h37;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    checkOutput("pre_rst_match_cnt", cnt_a,  1);
    checkOutput("pre_rst_busy",      busy_a, 1);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst_busy",      busy_a,        0);
    checkOutput("mid_rst_in_ready",  if_a.in_ready, 0);
    checkOutput("mid_rst_done",      done_a,        0);
    checkOutput("mid_rst_flag",      flag_a,        0);
    checkOutput("mid_rst_match_cnt", cnt_a,         0);
    checkOutput("mid_rst_match_cnt_b", cnt_b,       0);
    checkOutput("mid_rst_found",     found_a,       0);
    checkOutput("mid_rst_first_pos", fp_a,          0);
    reset    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_busy", busy_a, 0);
    applyStimulus(5'd2, {8'h03, 8'h70, 8'h00, 8'h00, 8'h00});
    checkOutput("post_rst_completed", m_completed, 1);
    checkOutput("post_rst_match_cnt", cnt_a,       1);
    checkOutput("post_rst_first_pos", fp_a,        11);
    checkOutput("post_rst_flags",     m_flags_a,   1);
    checkOutput("post_rst_done_at",   m_done_at,   19);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
